// File: rtl/approx_mult_pkg.sv
// Shared types and elaboration-time helpers for the row-serial approximate multiplier.
package approx_mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Upper bound on the product width the mask helper can describe.
  localparam int MAX_PW = 128;

  function automatic int n_digits(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Keep-mask for approximate rows: ones from column k up to the product width.
  function automatic logic [MAX_PW-1:0] approx_mask(input int width, input int k);
    logic [MAX_PW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PW; i++) m[i] = (i >= k) && (i < 2 * width);
    return m;
  endfunction

endpackage

// File: rtl/approx_pp_row.sv
// One partial-product row: a * digit, shifted to its column and optionally truncated.
module approx_pp_row
  import approx_mult_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int BPC      = 2,
  parameter int APPROX_K = 8,
  parameter int IDX_W    = 3
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [BPC-1:0]     digit_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               approx_en_i,
  output logic [2*WIDTH-1:0] row_o
);
  localparam int PW = 2 * WIDTH;
  localparam logic [MAX_PW-1:0] MASK_FULL = approx_mask(WIDTH, APPROX_K);
  localparam logic [PW-1:0]     MASK      = MASK_FULL[PW-1:0];

  logic [PW-1:0] prod;
  logic [PW-1:0] shifted;

  assign prod    = PW'(a_i) * PW'(digit_i);
  assign shifted = prod << (32'(idx_i) * BPC);
  assign row_o   = approx_en_i ? (shifted & MASK) : shifted;

endmodule

// File: rtl/approx_mult_seq.sv
// Iterative unsigned multiplier: one BPC-bit multiplier digit per CALC cycle,
// optional low-column truncation and early exit, valid/ready on both sides.
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BPC        = 2,
  parameter int APPROX_K   = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p_out,
  output logic               busy
);
  localparam int N     = n_digits(WIDTH, BPC);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             ap_q;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             load;

  logic [BPC-1:0]   digit;
  logic [WIDTH-1:0] rem;
  logic             last;
  logic [PW-1:0]    row;

  assign digit = BPC'(b_q >> (32'(cnt_q) * BPC));
  // Multiplier bits above the current digit; zero means all later rows are zero.
  assign rem   = b_q >> (32'(cnt_q) * BPC + BPC);
  assign last  = (cnt_q == IDX_W'(N - 1)) || ((EARLY_EXIT != 0) && (rem == '0));

  approx_pp_row #(
    .WIDTH(WIDTH), .BPC(BPC), .APPROX_K(APPROX_K), .IDX_W(IDX_W)
  ) u_row (
    .a_i(a_q), .digit_i(digit), .idx_i(cnt_q), .approx_en_i(ap_q), .row_o(row)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          acc_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      CALC: begin
        acc_d = acc_q + row;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          p_d     = acc_q + row;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ap_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      if (load) begin
        a_q  <= a_in;
        b_q  <= b_in;
        ap_q <= approx_en;
      end
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p_out     = p_q;

endmodule
